adc_avg_dac_fmt: RTL and testbench
==================================

Name: adc_avg_dac_fmt

Overview:
Sits directly downstream of the XADC DRP read port and directly upstream of the DAC SPI shift/control pair. Captures conversion results for one selected auxiliary channel and box-car averages 2^LOG2_N samples. Formats each average into the 16-bit DAC command word and presents it with a valid/ready handshake to the SPI controller. Replaces the ad-hoc accumulate-and-shift and word-assembly logic at the top level with a single-clock, resettable block.

Parameters:
CHANNEL, 5'h1E, XADC channel_out value whose samples are accepted
LOG2_N, 4, log2 of samples per average (1..8)
CMD_BITS, 3'b001, DAC command/address prefix placed in dac_word[15:13]
LOW_CLAMP, 12'd1, averages <= this value are replaced by CLAMP_CODE
CLAMP_CODE, 12'hFFF, code substituted when clamping

Ports:
clk  in  1  system clock (same domain as XADC dclk)
rst  in  1  synchronous, active-high reset
drdy_in  in  1  XADC drdy_out, one-cycle pulse per DRP read
channel_in  in  5  XADC channel_out
do_in  in  16  XADC do_out; result in [15:4]
word_ready  in  1  SPI controller idle and able to load a word
word_valid  out  1  dac_word holds an unconsumed command
dac_word  out  16  {CMD_BITS, code[11:0], 1'b0}
avg_out  out  12  last completed average, before clamping
avg_valid  out  1  one-cycle pulse when avg_out updates
overrun  out  1  sticky: an unconsumed word was overwritten

Behaviour:
- Reset (rst=1 at a clk edge): acc=0, count=0, avg_out=0, avg_valid=0, word_valid=0, dac_word=16'h0000, overrun=0, FSM=IDLE. Reset mid-accumulation discards the partial sum.
- Accept: sample accepted in a cycle with drdy_in=1 and channel_in==CHANNEL. Sample = do_in[15:4]. All other cycles leave acc and count unchanged.
- Accumulator width 12+LOG2_N, so it never overflows. count width LOG2_N, so it wraps naturally.
- Non-final accept (count != 2^LOG2_N-1): acc += sample, count += 1.
- Final accept: avg_out <= (acc+sample) >> LOG2_N (truncating), acc <= 0, count <= 0, avg_valid=1 on the next cycle.
- Latency: one cycle from the final accept edge to avg_out, avg_valid and the new dac_word/word_valid.
- Format: code = (avg <= LOW_CLAMP) ? CLAMP_CODE : avg. dac_word = {CMD_BITS, code, 1'b0}.
- Handshake FSM, IDLE/VALID:
  - IDLE: word_valid=0. A new average loads dac_word and moves to VALID.
  - VALID: word_valid=1, dac_word stable. word_ready=1 consumes the word and returns to IDLE.
  - VALID with a new average, word_ready=1 in the same cycle: the old word is consumed, the new one is loaded, the FSM stays in VALID, overrun is unchanged.
  - VALID with a new average, word_ready=0: dac_word is overwritten with the new word, the FSM stays in VALID, overrun<=1.
- overrun clears only on rst.
- word_ready while IDLE is ignored.
- dac_word holds its last value after consumption.

Decomposition:
- Shared package (adc_dac_pkg):
  - DAC command prefixes (CMD_BITS values for channels A-D)
  - FSM state enum {IDLE, VALID}
  - XADC channel constants (5'h1E, 5'h17, 5'h1F, 5'h16)
- One natural sub-module: adc_accum. It holds the accept/accumulate/divide path and produces avg and a done pulse. The top level holds the formatter, clamp and handshake FSM.

Test Plan:
- 16 accepts of do_in=16'h8000, word_ready=1 -> avg_out=12'h800, one avg_valid pulse, dac_word=16'h3000, word_valid high for exactly 1 cycle.
- Ramp do_in=i<<4, i=0..15 -> avg_out=12'h007, dac_word=16'h200E.
- 16 accepts of do_in=16'h0000 -> avg_out=0 (clamped), dac_word=16'h3FFE.
- Interleave 16 samples on channel 5'h17 (value 16'hFFF0) with 16 on CHANNEL (16'h8000) -> only one average is produced, avg_out=12'h800.
- word_ready=0 across two averages (12'h800 then 12'h400) -> dac_word=16'h2800, overrun=1, word_valid stays 1. Raising word_ready -> word_valid drops the next cycle.
- 7 accepts of 16'hFFF0, then rst, then 16 accepts of 16'h8000 -> avg_out=12'h800, overrun=0.

Source files
------------

// File: rtl/adc_dac_pkg.sv
// rtl/adc_dac_pkg.sv - shared constants, handshake state and DAC word formatter
package adc_dac_pkg;

  localparam logic [2:0] DAC_CMD_A = 3'b001;
  localparam logic [2:0] DAC_CMD_B = 3'b010;
  localparam logic [2:0] DAC_CMD_C = 3'b011;
  localparam logic [2:0] DAC_CMD_D = 3'b100;

  localparam logic [4:0] XADC_CH_VAUX14 = 5'h1E;
  localparam logic [4:0] XADC_CH_VAUX7  = 5'h17;
  localparam logic [4:0] XADC_CH_VAUX15 = 5'h1F;
  localparam logic [4:0] XADC_CH_VAUX6  = 5'h16;

  typedef enum logic {IDLE, VALID} hs_state_e;

  // Near-zero averages are treated as out of range and replaced by a safe code.
  function automatic logic [15:0] fmt_dac_word(input logic [2:0]  cmd,
                                               input logic [11:0] avg,
                                               input logic [11:0] low_clamp,
                                               input logic [11:0] clamp_code);
    logic [11:0] code;
    code = (avg <= low_clamp) ? clamp_code : avg;
    return {cmd, code, 1'b0};
  endfunction

endpackage

// File: rtl/adc_accum.sv
// rtl/adc_accum.sv - per-channel sample capture and 2^LOG2_N box-car average
module adc_accum import adc_dac_pkg::*; #(
  parameter logic [4:0] CHANNEL = XADC_CH_VAUX14,
  parameter int         LOG2_N  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        drdy_in,
  input  logic [4:0]  channel_in,
  input  logic [15:0] do_in,
  output logic [11:0] avg_next_o,
  output logic        final_o,
  output logic [11:0] avg_o,
  output logic        done_o
);

  localparam int ACC_W = 12 + LOG2_N;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0] count_q, count_d;
  logic [11:0]       avg_q, avg_d;
  logic              done_q, done_d;
  logic [11:0]       sample;
  logic [ACC_W-1:0]  sum;
  logic              accept;
  logic              unused_lsbs;

  assign sample      = do_in[15:4];
  assign unused_lsbs = ^do_in[3:0];
  assign accept      = drdy_in && (channel_in == CHANNEL);
  assign sum         = acc_q + ACC_W'(sample);
  assign final_o     = accept && (count_q == '1);
  assign avg_next_o  = sum[ACC_W-1:LOG2_N];

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    avg_d   = avg_q;
    done_d  = 1'b0;
    if (final_o) begin
      acc_d   = '0;
      count_d = '0;
      avg_d   = avg_next_o;
      done_d  = 1'b1;
    end else if (accept) begin
      acc_d   = sum;
      count_d = count_q + LOG2_N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
      avg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      avg_q   <= avg_d;
      done_q  <= done_d;
    end
  end

  assign avg_o  = avg_q;
  assign done_o = done_q;

endmodule

// File: rtl/adc_avg_dac_fmt.sv
// rtl/adc_avg_dac_fmt.sv - XADC channel averager feeding DAC command words over valid/ready
module adc_avg_dac_fmt import adc_dac_pkg::*; #(
  parameter logic [4:0]  CHANNEL    = XADC_CH_VAUX14,
  parameter int          LOG2_N     = 4,
  parameter logic [2:0]  CMD_BITS   = DAC_CMD_A,
  parameter logic [11:0] LOW_CLAMP  = 12'd1,
  parameter logic [11:0] CLAMP_CODE = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        drdy_in,
  input  logic [4:0]  channel_in,
  input  logic [15:0] do_in,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [15:0] dac_word,
  output logic [11:0] avg_out,
  output logic        avg_valid,
  output logic        overrun
);

  logic [11:0] avg_next;
  logic        avg_final;

  adc_accum #(
    .CHANNEL (CHANNEL),
    .LOG2_N  (LOG2_N)
  ) u_accum (
    .clk        (clk),
    .rst        (rst),
    .drdy_in    (drdy_in),
    .channel_in (channel_in),
    .do_in      (do_in),
    .avg_next_o (avg_next),
    .final_o    (avg_final),
    .avg_o      (avg_out),
    .done_o     (avg_valid)
  );

  hs_state_e   state_q, state_d;
  logic [15:0] dac_word_q, dac_word_d;
  logic        overrun_q, overrun_d;

  // The word is built from the not-yet-registered average so it lands with avg_out.
  always_comb begin
    state_d    = state_q;
    dac_word_d = dac_word_q;
    overrun_d  = overrun_q;
    case (state_q)
      IDLE: begin
        if (avg_final) begin
          dac_word_d = fmt_dac_word(CMD_BITS, avg_next, LOW_CLAMP, CLAMP_CODE);
          state_d    = VALID;
        end
      end
      VALID: begin
        if (avg_final) begin
          dac_word_d = fmt_dac_word(CMD_BITS, avg_next, LOW_CLAMP, CLAMP_CODE);
          if (!word_ready) overrun_d = 1'b1;
        end else if (word_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dac_word_q <= 16'h0000;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dac_word_q <= dac_word_d;
      overrun_q  <= overrun_d;
    end
  end

  assign word_valid = (state_q == VALID);
  assign dac_word   = dac_word_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_avg_dac_fmt.sv
// tb/tb_adc_avg_dac_fmt.sv - directed and random checks of adc_avg_dac_fmt against a sample-list model
module tb_adc_avg_dac_fmt;

  localparam logic [4:0] CH = 5'h1E;
  localparam int         N  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        drdy_in;
  logic [4:0]  channel_in;
  logic [15:0] do_in;
  logic        word_ready;
  logic        word_valid;
  logic [15:0] dac_word;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        overrun;

  always #5 clk = ~clk;

  adc_avg_dac_fmt #(
    .CHANNEL    (CH),
    .LOG2_N     (4),
    .CMD_BITS   (3'b001),
    .LOW_CLAMP  (12'd1),
    .CLAMP_CODE (12'hFFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .drdy_in    (drdy_in),
    .channel_in (channel_in),
    .do_in      (do_in),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .dac_word   (dac_word),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .overrun    (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  int unsigned samples[$];
  logic [11:0] m_avg;
  logic        m_avg_vld;
  logic        m_pending;
  logic [15:0] m_word;
  logic        m_ov;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] expect_word(input logic [11:0] a);
    logic [11:0] code;
    code = (a <= 12'd1) ? 12'hFFF : a;
    return {3'b001, code, 1'b0};
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic dv, input logic [4:0] ch,
                      input logic [15:0] d, input logic wr);
    logic        new_avg;
    int unsigned sum;
    rst = r; drdy_in = dv; channel_in = ch; do_in = d; word_ready = wr;
    @(posedge clk);
    new_avg = 1'b0;
    if (r) begin
      samples.delete();
      m_avg = 12'h000; m_avg_vld = 1'b0; m_pending = 1'b0; m_word = 16'h0000; m_ov = 1'b0;
    end else begin
      if (dv && ch == CH) begin
        samples.push_back(int'(d[15:4]));
        if (samples.size() == N) begin
          sum = 0;
          foreach (samples[i]) sum += samples[i];
          m_avg   = 12'(sum / N);
          new_avg = 1'b1;
          samples.delete();
        end
      end
      m_avg_vld = new_avg;
      if (new_avg) begin
        if (m_pending && !wr) m_ov = 1'b1;
        m_pending = 1'b1;
        m_word    = expect_word(m_avg);
      end else if (m_pending && wr) begin
        m_pending = 1'b0;
      end
    end
    #1;
    check("avg_out",    16'(avg_out),    16'(m_avg));
    check("avg_valid",  16'(avg_valid),  16'(m_avg_vld));
    check("word_valid", 16'(word_valid), 16'(m_pending));
    check("dac_word",   dac_word,        m_word);
    check("overrun",    16'(overrun),    16'(m_ov));
  endtask

  task automatic accepts(input int n, input logic [15:0] d, input logic wr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, CH, d, wr);
  endtask

  initial begin
    rst = 1'b1; drdy_in = 1'b0; channel_in = 5'h0; do_in = 16'h0; word_ready = 1'b0;
    m_avg = 12'h000; m_avg_vld = 1'b0; m_pending = 1'b0; m_word = 16'h0000; m_ov = 1'b0;

    step(1'b1, 1'b0, 5'h0, 16'h0, 1'b0);
    step(1'b1, 1'b1, CH, 16'hFFF0, 1'b1);
    check("reset_dac_word", dac_word, 16'h0000);
    check("reset_word_valid", 16'(word_valid), 16'h0);

    accepts(N, 16'h8000, 1'b1);
    check("mid_avg", 16'(avg_out), 16'h0800);
    check("mid_word", dac_word, 16'h3000);
    step(1'b0, 1'b0, CH, 16'h0, 1'b1);
    check("mid_consumed", 16'(word_valid), 16'h0);

    for (int i = 0; i < N; i++) step(1'b0, 1'b1, CH, 16'(i << 4), 1'b1);
    check("ramp_avg", 16'(avg_out), 16'h0007);
    check("ramp_word", dac_word, 16'h200E);
    step(1'b0, 1'b0, CH, 16'h0, 1'b1);

    accepts(N, 16'h0000, 1'b1);
    check("zero_word", dac_word, 16'h3FFE);
    step(1'b0, 1'b0, CH, 16'h0, 1'b1);

    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b1, 5'h17, 16'hFFF0, 1'b1);
      step(1'b0, 1'b1, CH, 16'h8000, 1'b1);
    end
    check("interleave_avg", 16'(avg_out), 16'h0800);
    step(1'b0, 1'b0, CH, 16'h0, 1'b1);

    accepts(N, 16'h8000, 1'b0);
    accepts(N, 16'h4000, 1'b0);
    step(1'b0, 1'b0, CH, 16'h0, 1'b0);
    check("ovr_word", dac_word, 16'h2800);
    check("ovr_flag", 16'(overrun), 16'h1);
    check("ovr_valid", 16'(word_valid), 16'h1);
    step(1'b0, 1'b0, CH, 16'h0, 1'b1);
    check("ovr_drain", 16'(word_valid), 16'h0);

    accepts(7, 16'hFFF0, 1'b1);
    step(1'b1, 1'b0, CH, 16'h0, 1'b1);
    accepts(N, 16'h8000, 1'b1);
    check("rst_mid_avg", 16'(avg_out), 16'h0800);
    check("rst_mid_ovr", 16'(overrun), 16'h0);

    for (int c = 0; c < 4000; c++) begin
      logic [4:0] ch;
      case ($urandom_range(0, 4))
        0, 1:    ch = CH;
        2:       ch = 5'h17;
        3:       ch = 5'h1F;
        default: ch = 5'($urandom);
      endcase
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), ch,
           16'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
